// File: rtl/softmax_norm.sv
// Softmax normalisation stage: buffers one row of exp values, accumulates their
// sum, then divides each element by the sum with a bit-serial restoring divider
// and streams the Q1.FRAC probabilities out over a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_COLLECT | accept row elements into row_buf and accumulate the sum
// S_DIVIDE  | one quotient bit per cycle for element k, OW cycles total
// S_OUTPUT  | present quotient of element k until downstream takes it
module softmax_norm #(
   parameter int SEQ_LEN = 16,
   parameter int DW      = 16,
   parameter int FRAC    = 15,
   parameter int OW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [OW-1:0] out_data,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy
);

   localparam int CW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int NW = $clog2(SEQ_LEN + 1);
   localparam int SW = DW + $clog2(SEQ_LEN);
   localparam int XW = DW + FRAC;
   localparam int BW = (OW > 1) ? $clog2(OW) : 1;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_DIVIDE  = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   k_q, k_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [SW-1:0]   rem_q, rem_d;
   logic [OW-1:0]   dvd_q, dvd_d;
   logic [OW-1:0]   quo_q, quo_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [DW-1:0]   row_buf_q [SEQ_LEN];

   logic            accept;
   logic            last_in;
   logic            last_k;
   logic [CW-1:0]   k_inc;
   logic [DW-1:0]   ld_x;
   logic [XW-1:0]   ld_full;
   logic [SW-1:0]   ld_rem;
   logic [OW-1:0]   ld_dvd;
   logic [SW:0]     rem_sh;
   logic            take_bit;
   logic [SW-1:0]   rem_next;

   assign in_ready  = (state_q == S_COLLECT) && !reset;
   assign accept    = in_valid && in_ready;
   assign last_in   = (cnt_q == NW'(SEQ_LEN - 1));
   assign last_k    = (k_q == CW'(SEQ_LEN - 1));
   assign k_inc     = k_q + 1'b1;

   assign out_valid = (state_q == S_OUTPUT);
   assign out_data  = out_valid ? quo_q : '0;
   assign out_last  = out_valid && last_k;
   assign busy      = (state_q != S_COLLECT) || (cnt_q != '0);

   // Divider preload: element about to be divided. Dividend x<<FRAC is split into
   // a starting remainder (bits above OW, always below sum) and the OW low bits
   // that get shifted in one per cycle. A one-element row uses in_data directly
   // because its buffer slot is being written in the same cycle.
   always_comb begin
      ld_x = row_buf_q[k_inc];
      if (state_q == S_COLLECT) begin
         ld_x = (cnt_q == '0) ? in_data : row_buf_q[0];
      end
      ld_full = XW'(ld_x) << FRAC;
      ld_rem  = SW'(ld_full >> OW);
      ld_dvd  = ld_full[OW-1:0];
   end

   // One restoring-division step; a zero sum never sets a quotient bit.
   always_comb begin
      rem_sh   = {rem_q, dvd_q[OW-1]};
      take_bit = (sum_q != '0) && (rem_sh >= {1'b0, sum_q});
      rem_next = take_bit ? SW'(rem_sh - {1'b0, sum_q}) : rem_sh[SW-1:0];
   end

   // Next-state and datapath updates for the three-state controller.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      sum_d   = sum_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      bit_d   = bit_q;
      case (state_q)
         S_COLLECT: begin
            if (accept) begin
               sum_d = sum_q + SW'(in_data);
               cnt_d = cnt_q + 1'b1;
               if (last_in) begin
                  state_d = S_DIVIDE;
                  k_d     = '0;
                  rem_d   = ld_rem;
                  dvd_d   = ld_dvd;
                  quo_d   = '0;
                  bit_d   = BW'(OW - 1);
               end
            end
         end
         S_DIVIDE: begin
            rem_d = rem_next;
            dvd_d = dvd_q << 1;
            quo_d = (quo_q << 1) | OW'(take_bit);
            if (bit_q == '0) begin
               state_d = S_OUTPUT;
            end else begin
               bit_d = bit_q - 1'b1;
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               if (!last_k) begin
                  state_d = S_DIVIDE;
                  k_d     = k_inc;
                  rem_d   = ld_rem;
                  dvd_d   = ld_dvd;
                  quo_d   = '0;
                  bit_d   = BW'(OW - 1);
               end else begin
                  state_d = S_COLLECT;
                  sum_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_COLLECT;
         end
      endcase
   end

   // Control and divider registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_COLLECT;
         cnt_q   <= '0;
         k_q     <= '0;
         sum_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         sum_q   <= sum_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         bit_q   <= bit_d;
      end
   end

   // Row storage; stale contents are harmless because cnt restarts at zero.
   always_ff @(posedge clk) begin
      if (accept) begin
         row_buf_q[cnt_q[CW-1:0]] <= in_data;
      end
   end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm with hand-computed row results.
module tb_softmax_norm;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        out_last;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] row_v  [16];
   logic [15:0] got_d  [16];
   logic        got_l  [16];
   logic        got_r  [16];
   int          got_t  [16];

   softmax_norm #(.SEQ_LEN(16), .DW(16), .FRAC(15), .OW(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // feed row_v[start..15], one element per accepted cycle
   task automatic send_row(input int start);
      for (int i = start; i < 16; i++) begin
         int g;
         g = 0;
         in_valid = 1'b1;
         in_data  = row_v[i];
         while (in_ready !== 1'b1 && g < 100) begin
            step();
            g++;
         end
         if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout elem %0d in_ready=%b required 1", i, in_ready);
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   // take n outputs with out_ready high, recording data/last/in_ready/time
   task automatic collect_row(input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         int g;
         g = 0;
         while (out_valid !== 1'b1 && g < 200) begin
            step();
            g++;
         end
         if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout elem %0d out_valid=%b required 1", i, out_valid);
         end
         got_d[i] = out_data;
         got_l[i] = out_last;
         got_r[i] = in_ready;
         got_t[i] = cyc;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      checks++;
      if ({out_valid, out_data, out_last, in_ready, busy} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%0d l=%b r=%b b=%b required all 0",
                  out_valid, out_data, out_last, in_ready, busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release in_ready=%b busy=%b required 1/0", in_ready, busy);
      end
   endtask

   task automatic test_uniform();
      for (int i = 0; i < 16; i++) row_v[i] = 16'd1000;
      send_row(0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL uniform_busy busy=%b in_ready=%b out_valid=%b required 1/0/0",
                  busy, in_ready, out_valid);
      end
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_d[i] !== 16'd2048 || got_l[i] !== (i == 15)) begin
            errors++;
            $display("FAIL uniform_elem %0d got %0d last=%b required 2048 last=%b",
                     i, got_d[i], got_l[i], (i == 15));
         end
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL uniform_idle busy=%b in_ready=%b required 0/1", busy, in_ready);
      end
   endtask

   task automatic test_one_hot();
      for (int i = 0; i < 16; i++) row_v[i] = (i == 5) ? 16'd4096 : 16'd0;
      send_row(0);
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_d[i] !== ((i == 5) ? 16'd32768 : 16'd0)) begin
            errors++;
            $display("FAIL one_hot_elem %0d got %0d required %0d",
                     i, got_d[i], (i == 5) ? 32768 : 0);
         end
      end
   endtask

   task automatic test_zero_row();
      for (int i = 0; i < 16; i++) row_v[i] = 16'd0;
      send_row(0);
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_d[i] !== 16'd0) begin
            errors++;
            $display("FAIL zero_elem %0d got %0d required 0", i, got_d[i]);
         end
         if (i > 0) begin
            checks++;
            if (got_t[i] - got_t[i-1] !== 17) begin
               errors++;
               $display("FAIL zero_spacing elem %0d got %0d cycles required 17",
                        i, got_t[i] - got_t[i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int g;
      for (int i = 0; i < 16; i++) row_v[i] = 16'd0;
      row_v[0] = 16'd1;
      row_v[1] = 16'd3;
      send_row(0);
      out_ready = 1'b0;
      g = 0;
      while (out_valid !== 1'b1 && g < 200) begin
         step();
         g++;
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'd8192 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cycle %0d got v=%b d=%0d l=%b required 1/8192/0",
                     c, out_valid, out_data, out_last);
         end
         step();
      end
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         logic [15:0] e;
         e = (i == 0) ? 16'd8192 : (i == 1) ? 16'd24576 : 16'd0;
         checks++;
         if (got_d[i] !== e) begin
            errors++;
            $display("FAIL backpressure_elem %0d got %0d required %0d", i, got_d[i], e);
         end
      end
   endtask

   task automatic test_reset_mid_divide();
      int seen;
      for (int i = 0; i < 16; i++) row_v[i] = 16'd1000;
      send_row(0);
      collect_row(3);
      step(); step(); step(); step(); step();
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_last, in_ready, busy} !== 20'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got v=%b d=%0d l=%b r=%b b=%b required all 0",
                  out_valid, out_data, out_last, in_ready, busy);
      end
      step(); step();
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ready got %b required 1", in_ready);
      end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_mid_stale got %0d out_valid cycles required 0", seen);
      end
      for (int i = 0; i < 16; i++) row_v[i] = 16'd500;
      send_row(0);
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_d[i] !== 16'd2048) begin
            errors++;
            $display("FAIL reset_mid_elem %0d got %0d required 2048", i, got_d[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) row_v[i] = 16'd1000;
      send_row(0);
      in_valid = 1'b1;
      in_data  = 16'd3;
      collect_row(16);
      checks++;
      if (got_l[15] !== 1'b1 || got_r[15] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_last_handshake last=%b in_ready=%b required 1/0", got_l[15], got_r[15]);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_next got %b required 1", in_ready);
      end
      step();
      for (int i = 0; i < 16; i++) row_v[i] = 16'd0;
      row_v[0] = 16'd3;
      row_v[1] = 16'd1;
      send_row(1);
      collect_row(16);
      for (int i = 0; i < 16; i++) begin
         logic [15:0] e;
         e = (i == 0) ? 16'd24576 : (i == 1) ? 16'd8192 : 16'd0;
         checks++;
         if (got_d[i] !== e) begin
            errors++;
            $display("FAIL b2b_elem %0d got %0d required %0d", i, got_d[i], e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_one_hot();
      test_zero_row();
      test_backpressure();
      test_reset_mid_divide();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
